icache_direct: RTL and testbench

- Direct-mapped instruction cache between the fetch stage and the instruction memory.
- Holds NUM_LINES lines. Each line is one BLOCK_SIZE-word block, filled from the memory's whole-block output.
- Hits return the instruction combinationally in the request cycle.
- Misses stall fetch for a fixed, parameterised fill latency that models memory access time.

---
 rtl/icache_direct.sv | 197 +++++++++++++++++++
 tb/tb_icache_direct.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : icache_direct                                                 |
// | Purpose  : Direct-mapped instruction cache between fetch and instruction |
// |            memory. Hits answer combinationally in the request cycle;     |
// |            misses stall for MISS_LATENCY wait cycles, then one whole     |
// |            block is written into the indexed line.                       |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            req, pc, flush        - fetch side inputs                     |
// |            inst, inst_valid,     - fetch side response                   |
// |            stall                                                         |
// |            mem_addr, mem_block   - block-aligned memory interface        |
// |            hit_count, miss_count - statistics (live with ICACHE_STATS_EN,|
// |                                    tied to zero otherwise)               |
// | Options  : `define ICACHE_STATS_EN builds the hit/miss counters          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module icache_direct #(
  parameter int WORD_SIZE    = 32,
  parameter int BLOCK_SIZE   = 16,
  parameter int NUM_LINES    = 8,
  parameter int MISS_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req,
  input  logic [WORD_SIZE-1:0]            pc,
  input  logic                            flush,
  output logic [WORD_SIZE-1:0]            inst,
  output logic                            inst_valid,
  output logic                            stall,
  output logic [WORD_SIZE-1:0]            mem_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_block,
  output logic [31:0]                     hit_count,
  output logic [31:0]                     miss_count
);

  localparam int OFF_W = 4;
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;
  localparam int CNT_W = $clog2(MISS_LATENCY + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [WORD_SIZE-1:0]   miss_addr;
  logic [WORD_SIZE-1:0]   miss_addr_nxt;

  // Line storage: only the valid bits are reset.
  logic [NUM_LINES-1:0]   valid;
  logic [TAG_W-1:0]       tags [NUM_LINES];
  logic [WORD_SIZE-1:0]   data [NUM_LINES][BLOCK_SIZE];

  // Lookup address split.
  logic [OFF_W-1:0]       offset;
  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       tag;
  logic [WORD_SIZE-1:0]   blk_addr;

  assign offset   = pc[OFF_W-1:0];
  assign index    = pc[OFF_W +: IDX_W];
  assign tag      = pc[WORD_SIZE-1 -: TAG_W];
  assign blk_addr = {pc[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};

  // Fill target comes from the registered miss address, never from pc,
  // so pc may wander during WAIT without corrupting the fill.
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;

  assign fill_idx = miss_addr[OFF_W +: IDX_W];
  assign fill_tag = miss_addr[WORD_SIZE-1 -: TAG_W];

  logic lookup_hit;
  logic start_miss;
  logic fill_done;

  assign lookup_hit = (state == S_IDLE) & req & valid[index] & (tags[index] == tag);
  assign start_miss = (state == S_IDLE) & req & ~lookup_hit;
  // flush wins over a fill completing in the same cycle.
  assign fill_done  = (state == S_WAIT) & (cnt == CNT_W'(MISS_LATENCY)) & ~flush;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      miss_addr <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      miss_addr <= miss_addr_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    miss_addr_nxt = miss_addr;
    inst_valid    = 1'b0;
    inst          = '0;
    stall         = 1'b0;
    mem_addr      = blk_addr;

    case (state)
      S_IDLE: begin
        inst_valid = lookup_hit;
        stall      = start_miss;
        if (lookup_hit) begin
          inst = data[index][offset];
        end
        if (start_miss) begin
          state_nxt     = S_WAIT;
          cnt_nxt       = CNT_W'(1);
          miss_addr_nxt = blk_addr;
        end
      end
      S_WAIT: begin
        stall    = req;
        mem_addr = miss_addr;
        if (flush || (cnt == CNT_W'(MISS_LATENCY))) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Valid bits
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else if (fill_done) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Tag and data arrays (no reset). Word 0 of mem_block sits in the MSBs.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tags[fill_idx] <= fill_tag;
      for (int w = 0; w < BLOCK_SIZE; w++) begin
        data[fill_idx][w] <= mem_block[WORD_SIZE*(BLOCK_SIZE-w)-1 -: WORD_SIZE];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (start_miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_icache_direct                                              |
// | Purpose  : Self-checking bench for icache_direct. Memory word n holds n, |
// |            so a correct hit always returns inst == pc.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_icache_direct;

  localparam int WS = 32;
  localparam int BS = 16;
  localparam int NL = 8;
  localparam int ML = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req;
  logic [WS-1:0]  pc;
  logic           flush;
  logic [WS-1:0]  inst;
  logic           inst_valid;
  logic           stall;
  logic [WS-1:0]  mem_addr;
  logic [WS*BS-1:0] mem_block;
  logic [31:0]    hit_count;
  logic [31:0]    miss_count;

  int n_vec = 0;
  int n_err = 0;

  icache_direct #(
    .WORD_SIZE   (WS),
    .BLOCK_SIZE  (BS),
    .NUM_LINES   (NL),
    .MISS_LATENCY(ML)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .pc         (pc),
    .flush      (flush),
    .inst       (inst),
    .inst_valid (inst_valid),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_block  (mem_block),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word n holds value n, word 0 in the MSBs.
  always_comb begin
    mem_block = '0;
    for (int i = 0; i < BS; i++) begin
      mem_block[WS*(BS-i)-1 -: WS] = mem_addr + 32'(i);
    end
  end

  // Expected statistic value: live counters only when the option is built.
  function automatic logic [31:0] stat(input int v);
`ifdef ICACHE_STATS_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    logic [65:0] got, exp;
    rst = 1'b1; req = 1'b0; flush = 1'b0; pc = 32'h1234;
    tick();
    tick();
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b0, 1'b0, 32'h0, 32'h1230};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want %h", got, exp);
    end
    n_vec++;
    if ({hit_count, miss_count} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_stats: got %h/%h want 0/0", hit_count, miss_count);
    end
    rst = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_cold_miss();
    logic [65:0] got, exp;
    req = 1'b1; pc = 32'h20;
    for (int c = 0; c <= ML; c++) begin
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b0, 1'b1, 32'h0, 32'h20};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL cold_miss_c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b1, 1'b0, 32'h20, 32'h20};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cold_miss_hit: got %h want %h", got, exp);
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_line_hits();
    logic [65:0] got, exp;
    for (int a = 32'h21; a <= 32'h2F; a++) begin
      pc = 32'(a);
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b1, 1'b0, 32'(a), 32'h20};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL line_hit_%h: got %h want %h", a, got, exp);
      end
      tick();
    end
    req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({hit_count, miss_count} !== {stat(16), stat(1)}) begin
      n_err++;
      $display("FAIL line_hit_stats: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, stat(16), stat(1));
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_conflict();
    logic [65:0] got, exp;
    logic [31:0] addrs [2];
    addrs[0] = 32'hA0;
    addrs[1] = 32'h20;
    for (int k = 0; k < 2; k++) begin
      req = 1'b1; pc = addrs[k];
      for (int c = 0; c <= ML; c++) begin
        @(negedge clk);
        got = {inst_valid, stall, inst, mem_addr};
        exp = {1'b0, 1'b1, 32'h0, addrs[k]};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL conflict_%h_c%0d: got %h want %h", addrs[k], c, got, exp);
        end
        tick();
      end
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b1, 1'b0, addrs[k], addrs[k]};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL conflict_%h_hit: got %h want %h", addrs[k], got, exp);
      end
      tick();
    end
    req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({hit_count, miss_count} !== {stat(18), stat(3)}) begin
      n_err++;
      $display("FAIL conflict_stats: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, stat(18), stat(3));
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_flush_mid_fill();
    logic [65:0] got, exp;
    req = 1'b1; pc = 32'h40;
    // Miss cycle, WAIT1, WAIT2 (flush pulsed in WAIT2).
    for (int c = 0; c < 3; c++) begin
      flush = (c == 2);
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b0, 1'b1, 32'h0, 32'h40};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL flush_fill_pre_c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
    flush = 1'b0;
    // Aborted fill: the held request re-misses with the full latency.
    for (int c = 0; c <= ML; c++) begin
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b0, 1'b1, 32'h0, 32'h40};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL flush_fill_restart_c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b1, 1'b0, 32'h40, 32'h40};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL flush_fill_hit: got %h want %h", got, exp);
    end
    tick();
    // Flush coinciding with a hit: the hit is still reported.
    pc = 32'h41; flush = 1'b1;
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b1, 1'b0, 32'h41, 32'h40};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL flush_idle_hit: got %h want %h", got, exp);
    end
    tick();
    flush = 1'b0;
    // Invalidation now visible: 0x41 and the older 0x20 line both miss.
    for (int k = 0; k < 2; k++) begin
      pc = (k == 0) ? 32'h41 : 32'h20;
      for (int c = 0; c <= ML; c++) begin
        @(negedge clk);
        got = {inst_valid, stall, inst, mem_addr};
        exp = {1'b0, 1'b1, 32'h0, {pc[31:4], 4'h0}};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL flush_after_%h_c%0d: got %h want %h", pc, c, got, exp);
        end
        tick();
      end
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b1, 1'b0, pc, {pc[31:4], 4'h0}};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL flush_after_%h_hit: got %h want %h", pc, got, exp);
      end
      tick();
    end
    req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({hit_count, miss_count} !== {stat(22), stat(7)}) begin
      n_err++;
      $display("FAIL flush_stats: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, stat(22), stat(7));
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset_mid_fill();
    logic [65:0] got, exp;
    // Clear the 0x40 line so the request below is a miss.
    req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    req = 1'b1; pc = 32'h40;
    // Miss cycle, WAIT1, WAIT2, WAIT3 (reset in WAIT3).
    for (int c = 0; c < 4; c++) begin
      rst = (c == 3);
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b0, 1'b1, 32'h0, 32'h40};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_fill_pre_c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({hit_count, miss_count} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_fill_stats0: got %0d/%0d want 0/0", hit_count, miss_count);
    end
    for (int c = 0; c <= ML; c++) begin
      if (c != 0) @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b0, 1'b1, 32'h0, 32'h40};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset_fill_restart_c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b1, 1'b0, 32'h40, 32'h40};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_fill_hit: got %h want %h", got, exp);
    end
    tick();
    req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({hit_count, miss_count} !== {stat(1), stat(1)}) begin
      n_err++;
      $display("FAIL reset_fill_stats: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, stat(1), stat(1));
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_req_drop();
    logic [65:0] got, exp;
    req = 1'b1; pc = 32'h60;
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b0, 1'b1, 32'h0, 32'h60};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL req_drop_miss: got %h want %h", got, exp);
    end
    tick();
    req = 1'b0;
    for (int c = 1; c <= ML + 2; c++) begin
      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr};
      exp = {1'b0, 1'b0, 32'h0, 32'h60};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL req_drop_c%0d: got %h want %h", c, got, exp);
      end
      tick();
    end
    req = 1'b1; pc = 32'h65;
    @(negedge clk);
    got = {inst_valid, stall, inst, mem_addr};
    exp = {1'b1, 1'b0, 32'h65, 32'h60};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL req_drop_hit: got %h want %h", got, exp);
    end
    tick();
    req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({hit_count, miss_count} !== {stat(2), stat(2)}) begin
      n_err++;
      $display("FAIL req_drop_stats: got %0d/%0d want %0d/%0d",
               hit_count, miss_count, stat(2), stat(2));
    end
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Random traffic against a block-level model: a set of resident block
  // numbers per line plus one outstanding fill with a countdown.
  task automatic test_random();
    bit          m_valid [NL];
    logic [27:0] m_blk   [NL];
    bit          busy;
    logic [27:0] fill_blk;
    int          left;
    int          hc, mc;
    logic [27:0] blk;
    int          idx;
    bit          hit;
    logic [129:0] got, exp;

    rst = 1'b1; req = 1'b0; flush = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    busy = 1'b0; fill_blk = '0; left = 0; hc = 0; mc = 0;

    for (int n = 0; n < 1500; n++) begin
      req   = ($urandom % 4) != 0;
      pc    = ((32'($urandom % 3)) << 7) | ((32'($urandom % NL)) << 4) | 32'($urandom % 16);
      if (($urandom % 8) == 0) pc = pc | ($urandom & 32'hFFFF_F800);
      flush = ($urandom % 32) == 0;
      rst   = ($urandom % 128) == 0;

      blk = pc[31:4];
      idx = int'(blk % NL);
      hit = !busy && req && m_valid[idx] && (m_blk[idx] == blk);
      if (busy)
        exp = {1'b0, req, 32'h0, {fill_blk, 4'h0}, stat(hc), stat(mc)};
      else
        exp = {hit, req && !hit, hit ? pc : 32'h0, {blk, 4'h0}, stat(hc), stat(mc)};

      @(negedge clk);
      got = {inst_valid, stall, inst, mem_addr, hit_count, miss_count};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random_%0d pc=%h req=%b: got %h want %h", n, pc, req, got, exp);
      end

      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        busy = 1'b0; hc = 0; mc = 0;
      end else begin
        if (!busy) begin
          if (hit) hc++;
          else if (req) begin
            busy = 1'b1; fill_blk = blk; left = ML; mc++;
          end
        end else if (flush) begin
          busy = 1'b0;
        end else begin
          left--;
          if (left == 0) begin
            m_valid[int'(fill_blk % NL)] = 1'b1;
            m_blk[int'(fill_blk % NL)]   = fill_blk;
            busy = 1'b0;
          end
        end
        if (flush) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      end
      #1;
    end
    rst = 1'b0; req = 1'b0; flush = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1; req = 1'b0; flush = 1'b0; pc = '0;
    test_reset();
    test_cold_miss();
    test_line_hits();
    test_conflict();
    test_flush_mid_fill();
    test_reset_mid_fill();
    test_req_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
